// File: rtl/window_shift_buffer.sv
// window_shift_buffer: sliding-window shift buffer with valid/ready on both sides,
// configurable stride and a zero-padded tail window emitted on flush.
//   clk, rst (async active-high)
//   in_valid/in_ready/data_in             : serial element input
//   flush                                 : pulse, close stream and emit the remainder
//   out_valid/out_ready/data_out          : TAPS-wide window, lane 0 = oldest
//   out_count/out_tail                    : valid lanes in window / last window flag
//   win_count                             : accepted-window counter, live only when
//                                           WINDOW_BUF_WIN_CNT_EN is defined, else 0
module window_shift_buffer #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 4,
    parameter int STRIDE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TAPS*DATA_W-1:0]    data_out,
    output logic [$clog2(TAPS+1)-1:0] out_count,
    output logic                      out_tail,
    output logic [15:0]               win_count
);
    localparam int CW = $clog2(TAPS+1);
    typedef enum logic [1:0] {FILL, FULL, TAIL} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] lanes [TAPS];
    logic tail, pend;
    logic accept, take, done;
    logic [CW-1:0] keep;
    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;
    assign done   = accept && cnt == CW'(TAPS-1);
    // elements retained after a window leaves; a tail window drains everything
    assign keep   = (state == FULL && !tail) ? CW'(TAPS-STRIDE) : '0;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= FILL;
        else     state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            FILL:    state_nx = done ? FULL : (flush && (cnt != '0 || accept)) ? TAIL : FILL;
            FULL:    state_nx = !take ? FULL : ((pend | flush) && keep != '0) ? TAIL : FILL;
            TAIL:    state_nx = take ? FILL : TAIL;
            default: state_nx = FILL;
        endcase
    end
    always_comb begin
        in_ready  = state == FILL;
        out_valid = state != FILL;
        out_tail  = state == TAIL || (state == FULL && tail);
        out_count = state == FULL ? CW'(TAPS) : state == TAIL ? cnt : '0;
    end
    for (genvar g = 0; g < TAPS; g++) begin : g_lane
        assign data_out[g*DATA_W +: DATA_W] = lanes[g];
    end
    // lanes at or above cnt are always zero, so a partial window is already padded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tail <= 1'b0;
            pend <= 1'b0;
            for (int i = 0; i < TAPS; i++) lanes[i] <= '0;
        end else begin
            pend <= state == FULL && !take && (pend | flush);
            if (accept) begin
                cnt  <= cnt + 1'b1;
                tail <= flush & done;
                for (int i = 0; i < TAPS; i++)
                    if (cnt == CW'(i)) lanes[i] <= data_in;
            end
            if (take) begin
                cnt  <= keep;
                tail <= 1'b0;
                if (keep != '0) begin
                    for (int i = 0; i < TAPS-STRIDE; i++) lanes[i] <= lanes[i+STRIDE];
                    for (int i = TAPS-STRIDE; i < TAPS; i++) lanes[i] <= '0;
                end else begin
                    for (int i = 0; i < TAPS; i++) lanes[i] <= '0;
                end
            end
        end
    end
`ifdef WINDOW_BUF_WIN_CNT_EN
    logic [15:0] wc;
    always_ff @(posedge clk or posedge rst)
        if (rst)       wc <= '0;
        else if (take) wc <= wc + 16'd1;
    assign win_count = wc;
`else
    assign win_count = 16'd0;
`endif
endmodule

// File: tb/tb_window_shift_buffer.sv
// tb_window_shift_buffer: directed bench for window_shift_buffer (STRIDE=1 and STRIDE=4 instances).
module tb_window_shift_buffer;
    logic clk = 0, rst = 1;
    logic a_in_valid = 0, a_flush = 0, a_out_ready = 0;
    logic [7:0] a_data_in = 0;
    logic a_in_ready, a_out_valid, a_out_tail;
    logic [31:0] a_data_out;
    logic [2:0] a_out_count;
    logic [15:0] a_win_count;
    logic b_in_valid = 0, b_flush = 0, b_out_ready = 0;
    logic [7:0] b_data_in = 0;
    logic b_in_ready, b_out_valid, b_out_tail;
    logic [31:0] b_data_out;
    logic [2:0] b_out_count;
    logic [15:0] b_win_count;
    int checks = 0, failures = 0, exp_wc = 0;
    always #5 clk = ~clk;
    window_shift_buffer #(.DATA_W(8), .TAPS(4), .STRIDE(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .data_in(a_data_in),
        .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready), .data_out(a_data_out),
        .out_count(a_out_count), .out_tail(a_out_tail), .win_count(a_win_count));
    window_shift_buffer #(.DATA_W(8), .TAPS(4), .STRIDE(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .data_in(b_data_in),
        .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready), .data_out(b_data_out),
        .out_count(b_out_count), .out_tail(b_out_tail), .win_count(b_win_count));
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [7:0] d);
        a_in_valid = 1; a_data_in = d;
        step();
        a_in_valid = 0;
    endtask
    task automatic take_a();
        a_out_ready = 1;
        step();
        a_out_ready = 0;
        exp_wc++;
    endtask
    function automatic logic [15:0] wc_exp();
`ifdef WINDOW_BUF_WIN_CNT_EN
        return 16'(exp_wc);
`else
        return 16'd0;
`endif
    endfunction
    initial begin
        step(); step();
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_count", a_out_count, 0);
        chk("rst_out_tail", a_out_tail, 0);
        chk("rst_data_out", a_data_out, 0);
        chk("rst_win_count", a_win_count, 0);
        rst = 0;
        step();
        // basic fill, consumer stalled
        push(8'h01); push(8'h02); push(8'h03);
        chk("t1_not_yet", a_out_valid, 0);
        push(8'h04);
        chk("t1_out_valid", a_out_valid, 1);
        chk("t1_data", a_data_out, 32'h04030201);
        chk("t1_count", a_out_count, 4);
        chk("t1_tail", a_out_tail, 0);
        chk("t1_in_ready", a_in_ready, 0);
        push(8'hFF);
        chk("t1_hold_data", a_data_out, 32'h04030201);
        chk("t1_hold_valid", a_out_valid, 1);
        // stride 1 overlap
        take_a();
        chk("t2_fill", a_in_ready, 1);
        chk("t2_win_count", a_win_count, wc_exp());
        push(8'h05);
        chk("t2_data", a_data_out, 32'h05040302);
        chk("t2_count", a_out_count, 4);
        // flush while a full window is held
        a_flush = 1; step(); a_flush = 0;
        chk("t5_held", a_data_out, 32'h05040302);
        chk("t5_held_tail", a_out_tail, 0);
        take_a();
        chk("t5_tail_valid", a_out_valid, 1);
        chk("t5_tail_flag", a_out_tail, 1);
        chk("t5_tail_count", a_out_count, 3);
        chk("t5_tail_data", a_data_out, 32'h00050403);
        take_a();
        chk("t5_after", a_in_ready, 1);
        chk("t5_after_valid", a_out_valid, 0);
        chk("t5_win_count", a_win_count, wc_exp());
        // partial window on flush
        push(8'h0A); push(8'h0B);
        a_flush = 1; step(); a_flush = 0;
        chk("t4_valid", a_out_valid, 1);
        chk("t4_tail", a_out_tail, 1);
        chk("t4_count", a_out_count, 2);
        chk("t4_data", a_data_out, 32'h00000B0A);
        take_a();
        chk("t4_in_ready", a_in_ready, 1);
        chk("t4_count0", a_out_count, 0);
        // flush on empty buffer is ignored
        a_flush = 1; step(); a_flush = 0;
        chk("empty_flush", a_out_valid, 0);
        // flush together with the completing accept
        push(8'h21); push(8'h22); push(8'h23);
        a_flush = 1; push(8'h24); a_flush = 0;
        chk("fa_data", a_data_out, 32'h24232221);
        chk("fa_tail", a_out_tail, 1);
        chk("fa_count", a_out_count, 4);
        take_a();
        chk("fa_drained", a_out_valid, 0);
        push(8'h31);
        a_flush = 1; step(); a_flush = 0;
        chk("fa_single_data", a_data_out, 32'h00000031);
        chk("fa_single_count", a_out_count, 1);
        take_a();
        // async reset mid-stream
        push(8'h41); push(8'h42); push(8'h43);
        #2 rst = 1; #1;
        chk("t6_rst_ready", a_in_ready, 1);
        chk("t6_rst_valid", a_out_valid, 0);
        exp_wc = 0;
        step(); rst = 0; step();
        chk("t6_rst_wc", a_win_count, wc_exp());
        a_flush = 1; step(); a_flush = 0;
        chk("t6_flush_none", a_out_valid, 0);
        push(8'h51); push(8'h52); push(8'h53);
        chk("t6_three", a_out_valid, 0);
        push(8'h54);
        chk("t6_four", a_out_valid, 1);
        chk("t6_data", a_data_out, 32'h54535251);
        #2 rst = 1; #1;
        chk("t6_rst_full", a_out_valid, 0);
        chk("t6_rst_full_ready", a_in_ready, 1);
        step(); rst = 0; step();
        // stride 4, consumer always ready
        b_out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1; b_data_in = 8'(8'h10 + i); step();
        end
        b_data_in = 8'h14;
        chk("t3_w0_data", b_data_out, 32'h13121110);
        chk("t3_w0_ready", b_in_ready, 0);
        step();
        chk("t3_ready_after", b_in_ready, 1);
        chk("t3_count0", b_out_count, 0);
        for (int i = 4; i < 8; i++) begin
            b_data_in = 8'(8'h10 + i); step();
        end
        b_in_valid = 0;
        chk("t3_w1_data", b_data_out, 32'h17161514);
        chk("t3_w1_valid", b_out_valid, 1);
        step();
        chk("t3_ready_end", b_in_ready, 1);
        chk("t3_valid_end", b_out_valid, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
